brmask_ctrl: RTL and testbench
==============================

BRMASK_CTRL -- requirements
Module: brmask_ctrl

Interface
REQ-001 Parameter: WIDTH_BRM, 4, number of branch tags and width of every branch mask (one-hot tags).
REQ-002 Port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: i_alloc_req  input  1  decode requests a tag for one branch/jump uop this cycle.
REQ-005 Port: o_alloc_gnt  output  1  combinational grant; the branch takes o_alloc_tag this cycle.
REQ-006 Port: o_alloc_tag  output  WIDTH_BRM  one-hot tag of the lowest-index free tag; 0 when none is free.
REQ-007 Port: o_brmask  output  WIDTH_BRM  registered mask of outstanding branches; attached to every uop dispatched this cycle.
REQ-008 Port: o_full  output  1  registered; all tags outstanding.
REQ-009 Port: i_res_valid  input  1  the branch unit resolves a branch this cycle.
REQ-010 Port: i_res_tag  input  WIDTH_BRM  one-hot tag of the resolving branch.
REQ-011 Port: i_brkill  input  1  qualifies i_res_valid: the branch mispredicted.
REQ-012 Port: o_clr_valid, o_clr_mask  output  1, WIDTH_BRM  registered; in-flight uops clear these bits from their brmask.
REQ-013 Port: o_kill_valid, o_kill_mask  output  1, WIDTH_BRM  registered; in-flight uops with (brmask & o_kill_mask) != 0 are squashed.

Function
REQ-014 State: outstanding mask (drives o_brmask) plus one dependency vector dep[t] of WIDTH_BRM bits per tag.
REQ-015 o_alloc_gnt = i_alloc_req & ~o_full & ~(i_res_valid & i_brkill).
REQ-016 On grant: tag t becomes outstanding next cycle; dep[t] <= current o_brmask with the bit of any tag resolved correctly this cycle cleared.
REQ-017 The allocated branch itself carries the current o_brmask, which never includes its own tag.
REQ-018 A tag freed in cycle N is allocatable no earlier than cycle N+1.
REQ-019 Correct resolve (i_res_valid=1, i_brkill=0, tag k outstanding): k cleared from outstanding mask and from every dep[t]; next cycle o_clr_valid=1, o_clr_mask=k.
REQ-020 Mispredict (i_res_valid=1, i_brkill=1, tag k outstanding): kill set K = k | {t outstanding : dep[t][k]=1}; K cleared from outstanding mask; next cycle o_kill_valid=1, o_kill_mask=K.
REQ-021 A resolve with a tag that is not outstanding, or with a tag that is zero or not one-hot, is ignored: no state change and no clr/kill pulse.
REQ-022 i_brkill without i_res_valid is ignored.
REQ-023 o_clr_valid and o_kill_valid are single-cycle pulses; masks are 0 when the matching valid is 0.
REQ-024 Latency: every registered output reflects an event one cycle after the edge on which the event is sampled.
REQ-025 o_full = (next outstanding mask == all ones), registered.

Reset
REQ-026 While i_rst_n=0 at a rising edge: outstanding mask, all dep[t], o_full, o_clr_valid, o_clr_mask, o_kill_valid, and o_kill_mask all become 0.
REQ-027 Reset overrides any same-cycle alloc or resolve; o_alloc_gnt is 0 while i_rst_n=0.

Structure
REQ-028 The WIDTH_BRM default and the one-hot-check helper go in the shared core package; the same package serves executeBR.
REQ-029 The lowest-index free-tag select is one sub-module, prio_onehot (WIDTH input vector -> one-hot output, 0 if the input is zero).

Verification
REQ-030 Reset: hold i_rst_n=0 for 1 edge -> o_brmask=0000, o_full=0; i_alloc_req=1 -> o_alloc_gnt=1, o_alloc_tag=0001.
REQ-031 Fill: 5 consecutive cycles with alloc_req -> tags 0001, 0010, 0100, 1000; o_brmask 0000, 0001, 0011, 0111, 1111; o_full=1 and no grant on the 5th request.
REQ-032 Correct resolve: full, res_tag=0010, brkill=0 -> next cycle o_clr_valid=1, o_clr_mask=0010, o_brmask=1101, o_full=0; the next alloc gets 0010.
REQ-033 Mispredict: tags allocated in order 0001, 0010, 0100, 1000; res_tag=0010, brkill=1 -> next cycle o_kill_valid=1, o_kill_mask=1110, o_brmask=0001.
REQ-034 Collisions: alloc_req together with a mispredict -> o_alloc_gnt=0. Alloc_req together with a correct resolve of 0001 while o_brmask=0011 -> new tag 0100 gets dep=0010. A resolve of a non-outstanding tag 1000 -> no pulse.
REQ-035 Reset mid-operation: o_brmask=0111 with a kill in flight, i_rst_n=0 -> next edge o_brmask=0000, o_kill_valid=0, o_clr_valid=0.

Source files
------------

// File: rtl/brmask_ctrl_pkg.sv
// brmask_ctrl_pkg: shared core constants and helpers for branch-mask tracking and executeBR.
package brmask_ctrl_pkg;
  localparam int WIDTH_BRM = 4;
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction
endpackage

// File: rtl/brmask_ctrl_if.sv
// brmask_ctrl_if: allocate/resolve/broadcast bundle between decode, branch unit and brmask_ctrl.
interface brmask_ctrl_if #(parameter int WIDTH_BRM = brmask_ctrl_pkg::WIDTH_BRM);
  logic                 i_alloc_req;
  logic                 o_alloc_gnt;
  logic [WIDTH_BRM-1:0] o_alloc_tag;
  logic [WIDTH_BRM-1:0] o_brmask;
  logic                 o_full;
  logic                 i_res_valid;
  logic [WIDTH_BRM-1:0] i_res_tag;
  logic                 i_brkill;
  logic                 o_clr_valid;
  logic [WIDTH_BRM-1:0] o_clr_mask;
  logic                 o_kill_valid;
  logic [WIDTH_BRM-1:0] o_kill_mask;
  modport master (
    output i_alloc_req, i_res_valid, i_res_tag, i_brkill,
    input  o_alloc_gnt, o_alloc_tag, o_brmask, o_full,
           o_clr_valid, o_clr_mask, o_kill_valid, o_kill_mask
  );
  modport slave (
    input  i_alloc_req, i_res_valid, i_res_tag, i_brkill,
    output o_alloc_gnt, o_alloc_tag, o_brmask, o_full,
           o_clr_valid, o_clr_mask, o_kill_valid, o_kill_mask
  );
endinterface

// File: rtl/brmask_ctrl_prio_onehot.sv
// prio_onehot: isolates the lowest set bit of a vector; zero in gives zero out.
module prio_onehot #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_onehot
);
  assign o_onehot = i_vec & (~i_vec + WIDTH'(1));
endmodule

// File: rtl/brmask_ctrl.sv
// brmask_ctrl: allocates one-hot branch tags and broadcasts branch clears/kills to in-flight uops.
module brmask_ctrl #(parameter int WIDTH_BRM = brmask_ctrl_pkg::WIDTH_BRM) (
  input logic         i_clk,
  input logic         i_rst_n,
  brmask_ctrl_if.slave bus
);
  import brmask_ctrl_pkg::*;
  logic [WIDTH_BRM-1:0] r_brmask, r_clr_mask, r_kill_mask;
  logic                 r_full, r_clr_valid, r_kill_valid;
  logic [WIDTH_BRM-1:0] r_dep [WIDTH_BRM];
  logic [WIDTH_BRM-1:0] w_free_tag, w_clr_bits, w_kill_set, w_alloc_bits, w_next_mask;
  logic                 w_res_ok, w_gnt;
  prio_onehot #(.WIDTH(WIDTH_BRM)) u_prio (.i_vec(~r_brmask), .o_onehot(w_free_tag));
  assign w_res_ok     = bus.i_res_valid && is_onehot(32'(bus.i_res_tag)) && |(bus.i_res_tag & r_brmask);
  assign w_gnt        = i_rst_n & bus.i_alloc_req & ~r_full & ~(bus.i_res_valid & bus.i_brkill);
  assign w_clr_bits   = (w_res_ok && !bus.i_brkill) ? bus.i_res_tag : '0;
  assign w_alloc_bits = w_gnt ? w_free_tag : '0;
  assign w_next_mask  = (r_brmask & ~(w_clr_bits | w_kill_set)) | w_alloc_bits;
  // A mispredict squashes the branch itself plus every younger branch that depends on it.
  always_comb begin
    w_kill_set = '0;
    if (w_res_ok && bus.i_brkill) begin
      w_kill_set = bus.i_res_tag;
      for (int t = 0; t < WIDTH_BRM; t++)
        if (r_brmask[t] && |(r_dep[t] & bus.i_res_tag)) w_kill_set[t] = 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_brmask     <= '0;
      r_full       <= 1'b0;
      r_clr_valid  <= 1'b0;
      r_clr_mask   <= '0;
      r_kill_valid <= 1'b0;
      r_kill_mask  <= '0;
      for (int t = 0; t < WIDTH_BRM; t++) r_dep[t] <= '0;
    end else begin
      r_brmask     <= w_next_mask;
      r_full       <= &w_next_mask;
      r_clr_valid  <= |w_clr_bits;
      r_clr_mask   <= w_clr_bits;
      r_kill_valid <= |w_kill_set;
      r_kill_mask  <= w_kill_set;
      for (int t = 0; t < WIDTH_BRM; t++)
        r_dep[t] <= w_alloc_bits[t] ? (r_brmask & ~w_clr_bits) : (r_dep[t] & ~(w_clr_bits | w_kill_set));
    end
  end
  assign bus.o_alloc_gnt  = w_gnt;
  assign bus.o_alloc_tag  = w_free_tag;
  assign bus.o_brmask     = r_brmask;
  assign bus.o_full       = r_full;
  assign bus.o_clr_valid  = r_clr_valid;
  assign bus.o_clr_mask   = r_clr_mask;
  assign bus.o_kill_valid = r_kill_valid;
  assign bus.o_kill_mask  = r_kill_mask;
endmodule

// File: tb/tb_brmask_ctrl.sv
// tb_brmask_ctrl: directed vector bench for brmask_ctrl allocation, resolve, kill and reset behaviour.
module tb_brmask_ctrl;
  typedef struct {
    logic       rst_n, req, rv;
    logic [3:0] rt;
    logic       bk, g, ct;
    logic [3:0] tag, bm;
    logic       full, cv;
    logic [3:0] cm;
    logic       kv;
    logic [3:0] km;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl [18];
  brmask_ctrl_if bus ();
  brmask_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", n, a, e);
    end
  endtask
  task automatic run(input string id, input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n;
    bus.i_alloc_req = v.req;
    bus.i_res_valid = v.rv;
    bus.i_res_tag = v.rt;
    bus.i_brkill = v.bk;
    #1;
    chk({id, ".gnt"}, {3'b0, bus.o_alloc_gnt}, {3'b0, v.g});
    if (v.ct) chk({id, ".tag"}, bus.o_alloc_tag, v.tag);
    @(posedge clk);
    #1;
    chk({id, ".brmask"}, bus.o_brmask, v.bm);
    chk({id, ".full"}, {3'b0, bus.o_full}, {3'b0, v.full});
    chk({id, ".clr_valid"}, {3'b0, bus.o_clr_valid}, {3'b0, v.cv});
    chk({id, ".clr_mask"}, bus.o_clr_mask, v.cm);
    chk({id, ".kill_valid"}, {3'b0, bus.o_kill_valid}, {3'b0, v.kv});
    chk({id, ".kill_mask"}, bus.o_kill_mask, v.km);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.i_alloc_req = 1'b0;
    bus.i_res_valid = 1'b0;
    bus.i_res_tag = '0;
    bus.i_brkill = 1'b0;
    //          rst req rv rt     bk  g  ct tag      bm      full cv cm      kv km
    tbl[0]  = '{0, 1, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[1]  = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[2]  = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0010, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[3]  = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0100, 4'b0111, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[4]  = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b1000, 4'b1111, 1, 0, 4'b0000, 0, 4'b0000};
    tbl[5]  = '{1, 1, 0, 4'b0000, 0, 0, 1, 4'b0000, 4'b1111, 1, 0, 4'b0000, 0, 4'b0000};
    tbl[6]  = '{1, 0, 1, 4'b0010, 0, 0, 1, 4'b0000, 4'b1101, 0, 1, 4'b0010, 0, 4'b0000};
    tbl[7]  = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0010, 4'b1111, 1, 0, 4'b0000, 0, 4'b0000};
    tbl[8]  = '{0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[9]  = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[10] = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0010, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[11] = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0100, 4'b0111, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[12] = '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b1000, 4'b1111, 1, 0, 4'b0000, 0, 4'b0000};
    tbl[13] = '{1, 1, 1, 4'b0010, 1, 0, 1, 4'b0000, 4'b0001, 0, 0, 4'b0000, 1, 4'b1110};
    tbl[14] = '{1, 0, 0, 4'b0000, 0, 0, 1, 4'b0010, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[15] = '{1, 0, 0, 4'b0001, 1, 0, 1, 4'b0010, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[16] = '{1, 0, 1, 4'b0101, 0, 0, 1, 4'b0010, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000};
    tbl[17] = '{1, 0, 1, 4'b0000, 1, 0, 1, 4'b0010, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000};
    for (int i = 0; i < 18; i++) run($sformatf("row%0d", i), tbl[i]);
    // New tag allocated alongside a correct resolve must depend only on the surviving older branch.
    run("coll_a1", '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0010, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000});
    run("coll_a2", '{1, 1, 1, 4'b0001, 0, 1, 1, 4'b0100, 4'b0110, 0, 1, 4'b0001, 0, 4'b0000});
    run("coll_a3", '{1, 1, 1, 4'b0010, 1, 0, 1, 4'b0001, 4'b0000, 0, 0, 4'b0000, 1, 4'b0110});
    run("coll_a4", '{1, 0, 1, 4'b1000, 0, 0, 1, 4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    run("rst_b1",  '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000});
    run("rst_b2",  '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0010, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000});
    run("rst_b3",  '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0100, 4'b0111, 0, 0, 4'b0000, 0, 4'b0000});
    run("rst_b4",  '{0, 1, 1, 4'b0100, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000});
    run("rst_b5",  '{1, 1, 0, 4'b0000, 0, 1, 1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
